driver_74hc165: RTL
===================

Name: driver_74hc165

Overview:
- Reads four daisy-chained 74HC165 parallel-in/serial-out chains (panel switches and buttons) and presents each chain as a WIDTH-bit parallel word.
- Input-side counterpart of the 74LV595 output driver on the same front panel. Uses the same serial clocking style.
- Scans continuously while scan_en is high. Pulses data_valid once per completed frame.

Parameters:
- WIDTH, 16, bits per chain (two '165s); legal range 2..32.
- HALF, 2, clk cycles per SRCLK half-period; must be >=2.
- LOAD_CYC, 2, clk cycles SH_LD_N is held low per frame; must be >=1.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- scan_en  in  1  enables frame scanning; sampled only in IDLE and DONE
- QH_0..QH_3  in  1 each  serial data from chain 0..3 (last '165 QH pin)
- SH_LD_N  out  1  shift/load, active-low parallel load
- SRCLK  out  1  shift clock to all chains
- data_0..data_3  out  WIDTH each  last completed frame, chain 0..3
- data_valid  out  1  one-clk pulse when data_0..3 update

Behaviour:
- Reset is synchronous, active-low, on clk; resetn=0 on a clk edge gives:
  - SH_LD_N=1, SRCLK=0.
  - data_0..3=0, data_valid=0.
  - All shift registers and counters cleared; state=IDLE.
- QH_0..3 are registered every clk (one input flop each). All sampling uses the registered copy.
- FSM:
  - IDLE: SH_LD_N=1, SRCLK=0. If scan_en, go to LOAD next cycle.
  - LOAD: SH_LD_N=0 for exactly LOAD_CYC cycles, then go to SETTLE.
  - SETTLE: SH_LD_N=1, SRCLK=0 for HALF cycles, then go to SHIFT with bit index 0.
  - SHIFT: WIDTH bit slots of 2*HALF cycles each.
    - SRCLK=0 for the first HALF cycles, 1 for the second HALF.
    - On the last low cycle of each slot, shift each chain's register left and insert its registered QH into the LSB.
    - The first sample is therefore the MSB of the frame word.
    - After slot WIDTH-1, go to DONE. WIDTH rising SRCLK edges are issued; the final edge is harmless.
  - DONE (1 cycle): data_k <= shift register k for all four chains simultaneously; data_valid=1. Next state is LOAD if scan_en, else IDLE.
- Frame period = LOAD_CYC + HALF + 2*HALF*WIDTH + 1 clk. Defaults give 69.
  - Counting the first LOAD cycle as cycle 0, data_valid is high in cycle 68 (defaults). The next LOAD begins at cycle 69.
- data_0..3 hold their value between frames and never change outside DONE.
- scan_en deasserted mid-frame: the current frame completes with a normal DONE/valid pulse, then IDLE.
- Reset mid-frame: immediate return to reset values. No partial word is ever published.
- SH_LD_N and SRCLK are driven directly from flops (glitch-free). SRCLK is never high while SH_LD_N=0.

Optional Feature:
- Macro: DRIVER_74HC165_DEBOUNCE_EN.
- Defined:
  - A per-chain candidate register stores each completed frame.
  - data_k updates only when a frame equals that chain's previous frame; other chains update independently.
  - data_valid pulses in DONE only if at least one chain updated.
  - After reset the candidate is 0, so the first nonzero frame never publishes.
- Undefined: every frame publishes and data_valid pulses every DONE, as above.

Decomposition:
- Shared include driver_74hc165_defs.vh holds:
  - state encodings IDLE/LOAD/SETTLE/SHIFT/DONE (3-bit);
  - default WIDTH/HALF/LOAD_CYC constants.
- One natural sub-module, serial_slot_timer. It owns:
  - the HALF-cycle phase counter and bit-slot counter;
  - the SRCLK level;
  - the single-cycle sample strobe and last-slot flag.
- The top owns the FSM, the input flops, the four shift registers and the output registers.

Test Plan:
- Reset/idle: resetn=0 for 3 cycles, then scan_en=0 for 100 cycles -> SH_LD_N=1, SRCLK=0, data_0..3=0, data_valid never asserted.
- Single frame, defaults: models present 0xA5C3, 0x0001, 0x8000, 0xFFFF and scan_en=1 for one cycle -> SH_LD_N low for cycles 0-1, 16 SRCLK rising edges, data_valid only at cycle 68, data_0..3 equal the presented words.
- Continuous scan: scan_en held high, chain 0 changes 0x1234 -> 0x4321 between frames -> data_valid every 69 cycles, data_0 follows one frame later, no extra pulses.
- scan_en dropped at cycle 30 -> frame completes with valid at cycle 68, then IDLE with no further LOAD.
- Reset at cycle 40 of a frame with data_0=0x00FF previously published -> outputs return to 0 next cycle; new frame starts from LOAD after scan_en.
- With DRIVER_74HC165_DEBOUNCE_EN: chain 1 presents 0x0F0F, 0x0F0E, 0x0F0E -> data_1 stays 0 after frames 1-2, becomes 0x0F0E after frame 3; data_valid suppressed on frames where no chain updated.

Source files
------------

// File: rtl/driver_74hc165_pkg.sv
// Shared state encodings and default geometry for the 74HC165 panel-input scanner.
package driver_74hc165_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_HALF     = 2;
  localparam int DEF_LOAD_CYC = 2;
  localparam int NUM_CHAINS   = 4;
  localparam int CNT_W        = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/driver_74hc165_serial_slot_timer.sv
// Bit-slot timing for the serial shift phase: phase/slot counters, registered SRCLK,
// mid-slot sample strobe and last-slot flag.
module driver_74hc165_serial_slot_timer #(
  parameter int WIDTH = 16,
  parameter int HALF  = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic active_i,
  input  logic active_nxt_i,
  output logic srclk_o,
  output logic sample_o,
  output logic last_slot_o
);

  localparam int PH_W  = $clog2(2 * HALF);
  localparam int BIT_W = $clog2(WIDTH);

  logic [PH_W-1:0]  ph_q, ph_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             srclk_q, srclk_d;
  logic             slot_end;

  assign slot_end = active_i && (ph_q == PH_W'(2 * HALF - 1));

  // Counters sit at zero outside SHIFT so the first slot starts cleanly.
  always_comb begin
    ph_d  = '0;
    bit_d = '0;
    if (active_i) begin
      ph_d  = slot_end ? '0 : ph_q + 1'b1;
      bit_d = slot_end ? bit_q + 1'b1 : bit_q;
    end
  end

  // SRCLK is registered against next-cycle phase so it lines up with ph_q.
  assign srclk_d = active_nxt_i && (ph_d >= PH_W'(HALF));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ph_q    <= '0;
      bit_q   <= '0;
      srclk_q <= 1'b0;
    end else begin
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      srclk_q <= srclk_d;
    end
  end

  assign srclk_o     = srclk_q;
  assign sample_o    = active_i && (ph_q == PH_W'(HALF - 1));
  assign last_slot_o = slot_end && (bit_q == BIT_W'(WIDTH - 1));

endmodule

// File: rtl/driver_74hc165.sv
// Scans four daisy-chained 74HC165 chains into parallel words.
// Optional DRIVER_74HC165_DEBOUNCE_EN: publish a chain only when two successive frames agree.
module driver_74hc165
  import driver_74hc165_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int HALF     = DEF_HALF,
  parameter int LOAD_CYC = DEF_LOAD_CYC
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             scan_en,
  input  logic             QH_0,
  input  logic             QH_1,
  input  logic             QH_2,
  input  logic             QH_3,
  output logic             SH_LD_N,
  output logic             SRCLK,
  output logic [WIDTH-1:0] data_0,
  output logic [WIDTH-1:0] data_1,
  output logic [WIDTH-1:0] data_2,
  output logic [WIDTH-1:0] data_3,
  output logic             data_valid
);

  state_e                               state_q, state_d;
  logic [CNT_W-1:0]                     cnt_q, cnt_d;
  logic [NUM_CHAINS-1:0]                qh_q;
  logic [NUM_CHAINS-1:0][WIDTH-1:0]     sr_q;
  logic [NUM_CHAINS-1:0][WIDTH-1:0]     data_q, data_d;
  logic                                 sh_ld_n_q, sh_ld_n_d;
  logic                                 valid_q, valid_d;
  logic                                 shift_act, shift_nxt, done_nxt;
  logic                                 sample, last_slot;
`ifdef DRIVER_74HC165_DEBOUNCE_EN
  logic [NUM_CHAINS-1:0][WIDTH-1:0]     cand_q, cand_d;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) qh_q <= '0;
    else         qh_q <= {QH_3, QH_2, QH_1, QH_0};
  end

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      ST_IDLE:   if (scan_en) state_d = ST_LOAD;
      ST_LOAD:   if (cnt_q == CNT_W'(LOAD_CYC - 1)) state_d = ST_SETTLE;
                 else cnt_d = cnt_q + 1'b1;
      ST_SETTLE: if (cnt_q == CNT_W'(HALF - 1)) state_d = ST_SHIFT;
                 else cnt_d = cnt_q + 1'b1;
      ST_SHIFT:  if (last_slot) state_d = ST_DONE;
      ST_DONE:   state_d = scan_en ? ST_LOAD : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign shift_act = (state_q == ST_SHIFT);
  assign shift_nxt = (state_d == ST_SHIFT);
  assign done_nxt  = (state_d == ST_DONE);

  driver_74hc165_serial_slot_timer #(
    .WIDTH (WIDTH),
    .HALF  (HALF)
  ) u_timer (
    .clk          (clk),
    .resetn       (resetn),
    .active_i     (shift_act),
    .active_nxt_i (shift_nxt),
    .srclk_o      (SRCLK),
    .sample_o     (sample),
    .last_slot_o  (last_slot)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sr_q <= '0;
    end else if (sample) begin
      for (int k = 0; k < NUM_CHAINS; k++)
        sr_q[k] <= {sr_q[k][WIDTH-2:0], qh_q[k]};
    end
  end

  // Output logic: computed from next state so the pins are plain flops and the
  // publish lands in the DONE cycle itself, together with data_valid.
  always_comb begin
    sh_ld_n_d = (state_d != ST_LOAD);
    data_d    = data_q;
    valid_d   = 1'b0;
`ifdef DRIVER_74HC165_DEBOUNCE_EN
    cand_d    = cand_q;
    if (done_nxt) begin
      for (int k = 0; k < NUM_CHAINS; k++) begin
        cand_d[k] = sr_q[k];
        // A chain counts as updated only when a confirmed word differs from what is shown.
        if (sr_q[k] == cand_q[k] && sr_q[k] != data_q[k]) begin
          data_d[k] = sr_q[k];
          valid_d   = 1'b1;
        end
      end
    end
`else
    if (done_nxt) begin
      data_d  = sr_q;
      valid_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sh_ld_n_q <= 1'b1;
      valid_q   <= 1'b0;
      data_q    <= '0;
`ifdef DRIVER_74HC165_DEBOUNCE_EN
      cand_q    <= '0;
`endif
    end else begin
      sh_ld_n_q <= sh_ld_n_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
`ifdef DRIVER_74HC165_DEBOUNCE_EN
      cand_q    <= cand_d;
`endif
    end
  end

  assign SH_LD_N    = sh_ld_n_q;
  assign data_valid = valid_q;
  assign data_0     = data_q[0];
  assign data_1     = data_q[1];
  assign data_2     = data_q[2];
  assign data_3     = data_q[3];

endmodule
